// File: rtl/alu_opcodes_pkg.sv
// rtl/alu_opcodes_pkg.sv - ALU opcode encoding shared by the ALU, the arbiter and its bench
package alu_opcodes_pkg;
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_XOR  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_AND  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_SLTS = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9;
    // comparison-only opcodes: flag result, data result stays 0
    localparam logic [4:0] ALU_LTS  = 5'd10;
    localparam logic [4:0] ALU_LTU  = 5'd11;
    localparam logic [4:0] ALU_GES  = 5'd12;
    localparam logic [4:0] ALU_GEU  = 5'd13;
    localparam logic [4:0] ALU_EQ   = 5'd14;
    localparam logic [4:0] ALU_NE   = 5'd15;
endpackage

// File: rtl/alu_riscv.sv
// rtl/alu_riscv.sv - combinational RISC-V style ALU with separate result and comparison flag
module alu_riscv #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [4:0]   op,
    output logic [N-1:0] result,
    output logic         flag
);
    import alu_opcodes_pkg::*;

    localparam int SW = $clog2(N);

    logic [SW-1:0] shamt;
    logic          lt_s;
    logic          lt_u;

    assign shamt = b[SW-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    // opcode decode; ops without a data result leave result at 0, ops without a flag leave flag at 0
    always_comb begin
        result = '0;
        flag   = 1'b0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_XOR:  result = a ^ b;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_SLTS: result = {{(N-1){1'b0}}, lt_s};
            ALU_SLTU: result = {{(N-1){1'b0}}, lt_u};
            ALU_LTS:  flag   = lt_s;
            ALU_LTU:  flag   = lt_u;
            ALU_GES:  flag   = ~lt_s;
            ALU_GEU:  flag   = ~lt_u;
            ALU_EQ:   flag   = (a == b);
            ALU_NE:   flag   = (a != b);
            default: begin
                result = '0;
                flag   = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester round-robin front end sharing one registered ALU
module alu_share_arbiter #(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req0_valid_i,
    input  logic         req1_valid_i,
    input  logic [N-1:0] req0_a_i,
    input  logic [N-1:0] req0_b_i,
    input  logic [N-1:0] req1_a_i,
    input  logic [N-1:0] req1_b_i,
    input  logic [4:0]   req0_op_i,
    input  logic [4:0]   req1_op_i,
    output logic         req0_ready_o,
    output logic         req1_ready_o,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic         rsp_id_o,
    output logic [N-1:0] result_o,
    output logic         flag_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic         ptr;
    logic         winner;
    logic         accept;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [4:0]   op_q;
    logic         id_q;
    logic [N-1:0] alu_result;
    logic         alu_flag;

    // the ALU sees only captured operands, so requester changes after acceptance cannot leak in
    alu_riscv #(.N(N)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .flag   (alu_flag)
    );

    // arbitration, grant and next state; grants are suppressed while reset is asserted
    always_comb begin
        state_nx     = state;
        accept       = 1'b0;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        winner       = (req0_valid_i && req1_valid_i) ? ptr : req1_valid_i;
        case (state)
            IDLE: begin
                if (req0_valid_i || req1_valid_i) begin
                    accept       = 1'b1;
                    req0_ready_o = ~winner;
                    req1_ready_o = winner;
                    state_nx     = EXEC;
                end
            end
            EXEC:    state_nx = RESP;
            RESP:    if (rsp_ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (rst_i) begin
            accept       = 1'b0;
            req0_ready_o = 1'b0;
            req1_ready_o = 1'b0;
        end
    end

    // state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    // capture the winner's operation on acceptance
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            id_q <= 1'b0;
        end else if (accept) begin
            a_q  <= winner ? req1_a_i  : req0_a_i;
            b_q  <= winner ? req1_b_i  : req0_b_i;
            op_q <= winner ? req1_op_i : req0_op_i;
            id_q <= winner;
        end
    end

    // register the ALU output at the end of the single execute cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_o <= '0;
            flag_o   <= 1'b0;
        end else if (state == EXEC) begin
            result_o <= alu_result;
            flag_o   <= alu_flag;
        end
    end

    // hand priority to the other requester once the response is taken
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                            ptr <= 1'b0;
        else if (state == RESP && rsp_ready_i) ptr <= ~id_q;
    end

    assign rsp_valid_o = (state == RESP);
    assign rsp_id_o    = id_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter
module tb_alu_share_arbiter;
    import alu_opcodes_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]   req0_op, req1_op;
    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_ready, rsp_id, flag;
    logic [N-1:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic         id;
        logic [N-1:0] res;
        logic         flg;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    alu_share_arbiter #(.N(N)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (req0_valid),
        .req1_valid_i (req1_valid),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .req0_op_i    (req0_op),
        .req1_op_i    (req1_op),
        .req0_ready_o (req0_ready),
        .req1_ready_o (req1_ready),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .result_o     (result),
        .flag_o       (flag)
    );

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic id, input logic [N-1:0] res, input logic flg);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.flg = flg;
        q.push_back(e);
    endtask

    task automatic set0(input logic v, input logic [4:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic set1(input logic v, input logic [4:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    // monitor: every completed response handshake is checked against the scoreboard head
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual=id%0d/%0h required=no response", rsp_id, result);
            end else begin
                mon_e = q.pop_front();
                chk("rsp_id", rsp_id, mon_e.id);
                chk("rsp_result", result, mon_e.res);
                chk("rsp_flag", flag, mon_e.flg);
            end
        end
    end

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        set0(1'b1, ALU_ADD, 32'd1, 32'd1);
        set1(1'b1, ALU_ADD, 32'd1, 32'd1);
        #3;
        // reset: ready gated even with valids high, outputs cleared
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flag", flag, 0);
        chk("rst_id", rsp_id, 0);
        set0(1'b0, ALU_ADD, 0, 0);
        set1(1'b0, ALU_ADD, 0, 0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        chk("idle_ready0", req0_ready, 0);

        // single ADD, latency check
        set0(1'b1, ALU_ADD, 32'd5, 32'd7);
        #1;
        chk("add_ready0", req0_ready, 1);
        chk("add_ready1", req1_ready, 0);
        push(1'b0, 32'd12, 1'b0);
        cyc();
        set0(1'b0, ALU_ADD, 0, 0);
        chk("add_exec_valid", rsp_valid, 0);
        chk("add_exec_ready0", req0_ready, 0);
        cyc();
        chk("add_resp_valid", rsp_valid, 1);
        cyc();
        chk("add_back_idle", rsp_valid, 0);

        // both valid after reset: req0 first, req1 held then served
        rst = 1'b1; cyc(); rst = 1'b0; cyc();
        set0(1'b1, ALU_SUB, 32'd10, 32'd3);
        set1(1'b1, ALU_XOR, 32'hF0, 32'h0F);
        #1;
        chk("both_ready0", req0_ready, 1);
        chk("both_ready1", req1_ready, 0);
        push(1'b0, 32'd7, 1'b0);
        push(1'b1, 32'hFF, 1'b0);
        cyc();
        req0_valid = 1'b0;
        chk("both_exec_ready1", req1_ready, 0);
        cyc();
        chk("both_resp_ready1", req1_ready, 0);
        cyc();
        chk("both_second_ready1", req1_ready, 1);
        cyc();
        req1_valid = 1'b0;
        cyc(); cyc();

        // continuous contention: grants alternate 0,1,0,1
        set0(1'b1, ALU_ADD, 32'd1, 32'd2);
        set1(1'b1, ALU_AND, 32'hC, 32'hA);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_ready0", req0_ready, (i % 2) == 0);
            chk("rr_ready1", req1_ready, (i % 2) == 1);
            push(i[0], i[0] ? 32'd8 : 32'd3, 1'b0);
            cyc();
            if (i == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            cyc(); cyc();
        end

        // LTS with back-pressure: single requester wins despite pointer at 0
        rsp_ready = 1'b0;
        set1(1'b1, ALU_LTS, 32'hFFFF_FFFF, 32'd1);
        #1;
        chk("lts_ready1", req1_ready, 1);
        chk("lts_ready0", req0_ready, 0);
        push(1'b1, 32'd0, 1'b1);
        cyc();
        req1_valid = 1'b0;
        chk("lts_exec_valid", rsp_valid, 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("hold_valid", rsp_valid, 1);
            chk("hold_result", result, 0);
            chk("hold_flag", flag, 1);
            chk("hold_id", rsp_id, 1);
        end
        cyc();
        chk("hold_last_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        cyc();
        chk("hold_released", rsp_valid, 0);

        // SRA with operand changed after acceptance
        set0(1'b1, ALU_SRA, 32'h8000_0000, 32'd4);
        #1;
        chk("sra_ready0", req0_ready, 1);
        push(1'b0, 32'hF800_0000, 1'b0);
        cyc();
        set0(1'b0, ALU_ADD, 32'd0, 32'd4);
        cyc();
        chk("sra_resp_valid", rsp_valid, 1);
        cyc();

        // reset during RESP discards the transaction and clears the pointer
        rsp_ready = 1'b0;
        set0(1'b1, ALU_ADD, 32'h11, 32'h22);
        cyc();
        req0_valid = 1'b0;
        cyc();
        chk("rstresp_valid_before", rsp_valid, 1);
        chk("rstresp_result_before", result, 32'h33);
        rst = 1'b1;
        #1;
        chk("rstresp_valid", rsp_valid, 0);
        chk("rstresp_result", result, 0);
        chk("rstresp_flag", flag, 0);
        cyc();
        rst = 1'b0;
        rsp_ready = 1'b1;
        set0(1'b1, ALU_ADD, 32'd2, 32'd3);
        set1(1'b1, ALU_OR, 32'h30, 32'h03);
        #1;
        chk("post_rst_ready0", req0_ready, 1);
        chk("post_rst_ready1", req1_ready, 0);
        push(1'b0, 32'd5, 1'b0);
        push(1'b1, 32'h33, 1'b0);
        cyc();
        req0_valid = 1'b0;
        cyc(); cyc();
        chk("post_rst_second", req1_ready, 1);
        cyc();
        req1_valid = 1'b0;
        cyc(); cyc();

        for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have ports req0_valid_i / req1_valid_i, input, 1 bit each: requester k presents an operation.
REQ-005 The block SHALL have ports req0_a_i, req0_b_i, req1_a_i, req1_b_i, input, N bits each: operands per requester.
REQ-006 The block SHALL have ports req0_op_i / req1_op_i, input, 5 bits each: ALU opcode, alu_opcodes_pkg encoding, passed through unchanged.
REQ-007 The block SHALL have ports req0_ready_o / req1_ready_o, output, 1 bit each: the request is accepted in this cycle.
REQ-008 The block SHALL have port rsp_valid_o, output, 1 bit: a response is held on the response ports.
REQ-009 The block SHALL have port rsp_ready_i, input, 1 bit: the consumer takes the response.
REQ-010 The block SHALL have port rsp_id_o, output, 1 bit: index of the requester that owns the response.
REQ-011 The block SHALL have port result_o, output, N bits: registered ALU result.
REQ-012 The block SHALL have port flag_o, output, 1 bit: registered ALU comparison flag.

Function
REQ-013 The block SHALL contain exactly one alu_riscv instance (N=N), driven only from internal operand and opcode registers.
REQ-014 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-015 IDLE: if any valid is high, the winner's ready_o SHALL be 1 combinationally in that cycle, and a, b, op and id SHALL be captured; next state is EXEC.
REQ-016 IDLE with no valid high SHALL stay in IDLE with both ready_o at 0.
REQ-017 Arbitration SHALL be round-robin over a 1-bit priority pointer. Both valid: the requester named by the pointer wins. One valid: that requester wins regardless of the pointer.
REQ-018 Only the winner's ready_o SHALL be high; ready_o SHALL be 0 in EXEC and RESP (one transaction outstanding).
REQ-019 EXEC SHALL last exactly one cycle: the ALU result and flag are registered into result_o and flag_o; next state is RESP.
REQ-020 RESP: rsp_valid_o SHALL be 1. rsp_id_o, result_o and flag_o SHALL stay stable while rsp_ready_i is 0.
REQ-021 In RESP with rsp_ready_i at 1: return to IDLE, and the pointer SHALL become the non-served requester.
REQ-022 Latency: acceptance at edge T SHALL give rsp_valid_o=1 after edge T+2. Minimum initiation interval is 3 cycles.
REQ-023 Requester valid, operand or op changes after acceptance SHALL NOT affect the outstanding result.
REQ-024 Opcodes with no result (comparison-only) SHALL return the ALU's result_o unchanged (0). Opcodes with no flag SHALL return flag 0.
REQ-025 A requester not granted SHALL keep waiting; the block SHALL NOT drop or reorder a held request.

Reset
REQ-026 rst_i high SHALL force IDLE, pointer=0, rsp_valid_o=0, rsp_id_o=0, result_o=0, flag_o=0, and all ready_o=0, asynchronously.
REQ-027 Reset in EXEC or RESP SHALL discard the outstanding transaction with no response.
REQ-028 After release, the first edge with a valid request SHALL be treated as IDLE arbitration.

Verification
REQ-029 Scenario: req0 ALU_ADD a=5, b=7, rsp_ready_i=1 -> req0_ready_o=1 at T, rsp_valid_o=1 after T+2, result_o=12, rsp_id_o=0.
REQ-030 Scenario: both valid after reset, req0 ALU_SUB 10-3 and req1 ALU_XOR 0xF0^0x0F held -> req0 served first (result 7), then req1 (result 0xFF, id 1).
REQ-031 Scenario: both valid continuously for 4 transactions -> grants alternate 0,1,0,1; neither requester is served twice in a row.
REQ-032 Scenario: req1 ALU_LTS a=0xFFFFFFFF, b=1, rsp_ready_i held 0 for 5 cycles -> flag_o=1, result_o=0; outputs stable and rsp_valid_o=1 throughout; released on the first rsp_ready_i=1.
REQ-033 Scenario: req0 ALU_SRA a=0x80000000, b=4; change req0_a_i to 0 after acceptance -> result_o=0xF8000000.
REQ-034 Scenario: rst_i pulsed during RESP -> rsp_valid_o and result_o go to 0 immediately; no response for that transaction; the pointer is back to 0.
